// File: rtl/reduce_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : reduce_dispatcher
// Description : Hands out point indices to the reducers in strict round-robin
//               order over per-reducer valid/ready handshakes. Counts each
//               reducer's completion acks into packed counters for the
//               accumulator, strobes the accumulator clear, and waits for the
//               accumulator done flag before pulsing job completion.
//               Optional drain watchdog: define DISPATCH_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module reduce_dispatcher #(
    parameter  int NUM_OF_REDUCERS = 2,
    parameter  int NUM_PTS         = 3,
    parameter  int TIMEOUT_CYCLES  = 1024,
    localparam int SUM_WIDTH       = 32
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 i_start,
    output logic                                 o_busy,
    output logic [NUM_OF_REDUCERS-1:0]           o_pt_valid,
    input  logic [NUM_OF_REDUCERS-1:0]           i_pt_ready,
    output logic [SUM_WIDTH-1:0]                 o_pt_index,
    input  logic [NUM_OF_REDUCERS-1:0]           i_reduce_ack,
    output logic [NUM_OF_REDUCERS*SUM_WIDTH-1:0] o_reduce_counters,
    output logic                                 o_res,
    input  logic                                 i_done,
    output logic                                 o_job_done,
    output logic                                 o_timeout
);

    localparam int PTR_W = (NUM_OF_REDUCERS > 1) ? $clog2(NUM_OF_REDUCERS) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_OF_REDUCERS - 1);
    localparam logic [31:0]      PTS_TOTAL = 32'(NUM_PTS);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_DISPATCH = 3'd2,
        S_DRAIN    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                               state_q,  state_d;
    logic [PTR_W-1:0]                     ptr_q,    ptr_d;
    logic [31:0]                          issued_q, issued_d;
    logic [SUM_WIDTH-1:0]                 index_q,  index_d;
    logic [NUM_OF_REDUCERS-1:0]           valid_q,  valid_d;
    logic [NUM_OF_REDUCERS*SUM_WIDTH-1:0] cnt_q,    cnt_d;
    logic                                 busy_q,   busy_d;
    logic                                 res_q,    res_d;
    logic                                 jdone_q,  jdone_d;
    logic                                 handshake;

`ifdef DISPATCH_TIMEOUT_EN
    logic [31:0] wd_q, wd_d;
    logic        tmo_q, tmo_d;
`else
    // Watchdog limit has no meaning when the watchdog is compiled out.
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

    // Next-state, issue bookkeeping, ack counting and registered output values.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        issued_d  = issued_q;
        index_d   = index_q;
        cnt_d     = cnt_q;
        // valid_q is only ever one-hot at ptr_q, so this is valid[ptr] & ready[ptr]
        handshake = (state_q == S_DISPATCH) && (|(valid_q & i_pt_ready));
`ifdef DISPATCH_TIMEOUT_EN
        wd_d      = '0;
        tmo_d     = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_DISPATCH;
            end
            S_DISPATCH: begin
                if (handshake) begin
                    index_d  = index_q + 32'd1;
                    issued_d = issued_q + 32'd1;
                    ptr_d    = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
                end
                // Also covers NUM_PTS == 0: one DISPATCH cycle, no valid.
                if (issued_d == PTS_TOTAL) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (i_done) begin
                    state_d = S_DONE;
                end
`ifdef DISPATCH_TIMEOUT_EN
                else if (wd_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 32'd1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Acks only belong to the current job once the clear has been issued.
        if ((state_q == S_DISPATCH) || (state_q == S_DRAIN) || (state_q == S_DONE)) begin
            for (int r = 0; r < NUM_OF_REDUCERS; r++) begin
                if (i_reduce_ack[r]) begin
                    cnt_d[r*SUM_WIDTH +: SUM_WIDTH] = cnt_q[r*SUM_WIDTH +: SUM_WIDTH] + SUM_WIDTH'(1);
                end
            end
        end

        // Zero on entry so counters already read 0 while the clear strobe is high.
        if (state_d == S_CLEAR) begin
            cnt_d    = '0;
            index_d  = '0;
            ptr_d    = '0;
            issued_d = '0;
        end

        busy_d  = (state_d != S_IDLE);
        res_d   = (state_d == S_CLEAR);
        jdone_d = (state_d == S_DONE);
        valid_d = ((state_d == S_DISPATCH) && (issued_d != PTS_TOTAL))
                  ? (NUM_OF_REDUCERS'(1) << ptr_d) : '0;
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            issued_q <= '0;
            index_q  <= '0;
            valid_q  <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            res_q    <= 1'b0;
            jdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            issued_q <= issued_d;
            index_q  <= index_d;
            valid_q  <= valid_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            res_q    <= res_d;
            jdone_q  <= jdone_d;
        end
    end

`ifdef DISPATCH_TIMEOUT_EN
    // Drain watchdog counter and its one-cycle pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_q  <= '0;
            tmo_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            tmo_q <= tmo_d;
        end
    end
    assign o_timeout = tmo_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_busy            = busy_q;
    assign o_pt_valid        = valid_q;
    assign o_pt_index        = index_q;
    assign o_reduce_counters = cnt_q;
    assign o_res             = res_q;
    assign o_job_done        = jdone_q;

endmodule
`default_nettype wire
